// File: rtl/anita3_trig_pkg.sv
// Shared types and constants for the ANITA-3 trigger buffer manager.
// Source bit order matches trig_mask_i and trig_type_o.
package anita3_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FULL  = 2'd3
    } trig_state_t;

    localparam int SRC_RF   = 0;
    localparam int SRC_PPS  = 1;
    localparam int SRC_EXT  = 2;
    localparam int SRC_SOFT = 3;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/anita3_buf_ring.sv
// SURF event buffer ring: write pointer plus per-buffer busy flags.
// Allocation and clear both land at the end of the cycle; no backpressure, the caller checks wr_busy.
module anita3_buf_ring
    import anita3_trig_pkg::*;
#(
    parameter int NUM_BUF = 4,
    localparam int PTR_W  = $clog2(NUM_BUF)
) (
    input  logic               clk250_i,
    input  logic               rst_n_i,
    input  logic               alloc,
    input  logic               clear,
    input  logic [PTR_W-1:0]   clear_buf,
    output logic [PTR_W-1:0]   wr_ptr,
    output logic               wr_busy,
    output logic [NUM_BUF-1:0] buf_busy
);

    logic [NUM_BUF-1:0] busy_nxt;

    // Set is applied after clear, so a same-cycle clear never undoes an allocation.
    always_comb begin
        busy_nxt = buf_busy;
        if (clear) busy_nxt[clear_buf] = 1'b0;
        if (alloc) busy_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk250_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            buf_busy <= '0;
        end else begin
            if (alloc) wr_ptr <= wr_ptr + PTR_W'(1);
            buf_busy <= busy_nxt;
        end
    end

    assign wr_busy = buf_busy[wr_ptr];

endmodule

// File: rtl/anita3_trig_buffer_manager.sv
// Arbitrates RF/PPS/ext/soft trigger requests onto a ring of SURF buffers with holdoff.
// Latency 1 cycle (RF 2, via edge detect); requests while busy are dropped and counted, one soft request is held.
// TRIG_DEADTIME_COUNT_EN builds the FULL-state deadtime counter; otherwise deadtime_count_o reads 0.
module anita3_trig_buffer_manager
    import anita3_trig_pkg::*;
#(
    parameter int NUM_BUF        = 4,
    parameter int HOLDOFF_CYCLES = 32,
    localparam int PTR_W         = $clog2(NUM_BUF)
) (
    input  logic               clk250_i,
    input  logic               rst_n_i,
    input  logic               rf_trig_i,
    input  logic               soft_trig_i,
    input  logic               pps_trig_i,
    input  logic               ext_trig_i,
    input  logic [3:0]         trig_mask_i,
    input  logic               disable_i,
    input  logic               clear_i,
    input  logic [PTR_W-1:0]   clear_buf_i,
    output logic               trig_o,
    output logic [PTR_W-1:0]   trig_buf_o,
    output logic [3:0]         trig_type_o,
    output logic [NUM_BUF-1:0] buf_busy_o,
    output logic [CNT_W-1:0]   event_count_o,
    output logic [CNT_W-1:0]   lost_count_o,
    output logic [CNT_W-1:0]   deadtime_count_o
);

    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 2);

    trig_state_t       state;
    logic              rf_prev, rf_edge_q, soft_pend;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic              wr_busy;
    logic [3:0]        src_raw, pend_vec, src_req, issue_set;
    logic              hold_done, alloc, blocked, pend_used, soft_lost, clr_hit;
    logic [2:0]        lost_inc;
    logic [CNT_W:0]    lost_sum;

    always_comb begin
        src_raw            = '0;
        src_raw[SRC_RF]    = rf_edge_q;
        src_raw[SRC_PPS]   = pps_trig_i;
        src_raw[SRC_EXT]   = ext_trig_i;
        src_raw[SRC_SOFT]  = soft_trig_i;
        pend_vec           = '0;
        pend_vec[SRC_SOFT] = soft_pend;
    end

    assign src_req   = src_raw & ~trig_mask_i;
    // The last HOLD cycle may launch a held soft request directly so it lands exactly one holdoff later.
    assign issue_set = (state == ST_IDLE) ? ((src_raw | pend_vec) & ~trig_mask_i)
                                          : (pend_vec & ~trig_mask_i);
    assign hold_done = (state == ST_HOLD) && (hold_cnt == HOLD_LAST);
    assign alloc     = !disable_i && !wr_busy && (|issue_set) && ((state == ST_IDLE) || hold_done);
    assign blocked   = !disable_i && ((state != ST_IDLE) || wr_busy);
    assign pend_used = alloc && issue_set[SRC_SOFT] && soft_pend;
    assign soft_lost = blocked && src_req[SRC_SOFT] && soft_pend && !pend_used;
    assign lost_inc  = blocked ? (3'(src_req[SRC_RF]) + 3'(src_req[SRC_PPS]) +
                                  3'(src_req[SRC_EXT]) + 3'(soft_lost)) : 3'd0;
    assign lost_sum  = {1'b0, lost_count_o} + (CNT_W+1)'(lost_inc);
    assign clr_hit   = clear_i && (clear_buf_i == wr_ptr);

    anita3_buf_ring #(
        .NUM_BUF(NUM_BUF)
    ) u_ring (
        .clk250_i (clk250_i),
        .rst_n_i  (rst_n_i),
        .alloc    (alloc),
        .clear    (clear_i),
        .clear_buf(clear_buf_i),
        .wr_ptr   (wr_ptr),
        .wr_busy  (wr_busy),
        .buf_busy (buf_busy_o)
    );

    always_ff @(posedge clk250_i) begin
        if (!rst_n_i) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            rf_prev       <= 1'b0;
            rf_edge_q     <= 1'b0;
            soft_pend     <= 1'b0;
            trig_o        <= 1'b0;
            trig_buf_o    <= '0;
            trig_type_o   <= '0;
            event_count_o <= '0;
            lost_count_o  <= '0;
        end else begin
            rf_prev     <= rf_trig_i;
            rf_edge_q   <= rf_trig_i & ~rf_prev;
            trig_o      <= alloc;
            trig_buf_o  <= alloc ? wr_ptr : '0;
            trig_type_o <= alloc ? issue_set : '0;
            if (alloc) event_count_o <= event_count_o + CNT_W'(1);
            lost_count_o <= lost_sum[CNT_W] ? CNT_MAX : lost_sum[CNT_W-1:0];

            if (pend_used)                           soft_pend <= blocked && src_req[SRC_SOFT];
            else if (blocked && src_req[SRC_SOFT])   soft_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (alloc)                                      state <= ST_ISSUE;
                    else if (!disable_i && (|issue_set) && wr_busy) state <= ST_FULL;
                end
                ST_ISSUE: begin
                    hold_cnt <= '0;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        if (alloc)        state <= ST_ISSUE;
                        else if (wr_busy) state <= ST_FULL;
                        else              state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_FULL: begin
                    if (!wr_busy || clr_hit) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TRIG_DEADTIME_COUNT_EN
    logic [CNT_W-1:0] dead_cnt;

    always_ff @(posedge clk250_i) begin
        if (!rst_n_i)                                       dead_cnt <= '0;
        else if ((state == ST_FULL) && (dead_cnt != CNT_MAX)) dead_cnt <= dead_cnt + CNT_W'(1);
    end

    assign deadtime_count_o = dead_cnt;
`else
    assign deadtime_count_o = '0;
`endif

endmodule

// File: doc/anita3_trig_buffer_manager.md
ANITA3_TRIG_BUFFER_MANAGER -- requirements
Module: anita3_trig_buffer_manager

Interface
REQ-001 Parameter NUM_BUF, default 4: number of SURF event buffers, power of two, 2..8.
REQ-002 Parameter HOLDOFF_CYCLES, default 32: minimum clk250_i cycles between issued triggers (128 ns).
REQ-003 clk250_i  in  1  250 MHz clock; all logic on its rising edge.
REQ-004 rst_n_i  in  1  synchronous reset, active-low.
REQ-005 rf_trig_i  in  1  RF trigger from the phi-sector trigger logic, level or pulse; rising edge is the request.
REQ-006 soft_trig_i / pps_trig_i / ext_trig_i  in  1 each  single-cycle request pulses from software, PPS and external input.
REQ-007 trig_mask_i  in  4  per-source enable mask, bit 0 RF, 1 PPS, 2 ext, 3 soft; 1 = masked.
REQ-008 disable_i  in  1  global disable; while high, no trigger issues and no request is counted as lost.
REQ-009 clear_i  in  1  one-cycle pulse: buffer clear_buf_i has been read out.
REQ-010 clear_buf_i  in  log2(NUM_BUF)  index of the buffer being released.
REQ-011 trig_o  out  1  one-cycle trigger pulse to the SURFs.
REQ-012 trig_buf_o  out  log2(NUM_BUF)  buffer assigned to trig_o; valid only with trig_o.
REQ-013 trig_type_o  out  4  all unmasked sources requesting in the sampling cycle (same bit order as trig_mask_i); valid with trig_o.
REQ-014 buf_busy_o  out  NUM_BUF  per-buffer occupied flags.
REQ-015 event_count_o  out  16  issued-trigger counter, wraps at 16 bits.
REQ-016 lost_count_o  out  16  dropped-request counter, saturates at 0xFFFF.
REQ-017 deadtime_count_o  out  16  cycles spent in FULL, saturating.

Function
REQ-018 States are IDLE, ISSUE, HOLD and FULL.
REQ-019 IDLE: an unmasked request, with disable_i low and buffer wr_ptr free, moves the block to ISSUE on the next cycle.
REQ-020 ISSUE lasts one cycle.
  - trig_o=1, trig_buf_o=wr_ptr, trig_type_o=sampled request set.
  - buf_busy_o[wr_ptr] sets, wr_ptr increments modulo NUM_BUF, event_count_o increments.
  - The block then moves to HOLD.
REQ-021 Latency: request on cycle N gives trig_o on cycle N+1; RF rising edge detection adds one cycle (rf_trig_i edge on N gives trig_o on N+2).
REQ-022 HOLD counts HOLDOFF_CYCLES-1 cycles, so trig_o pulses are spaced by at least HOLDOFF_CYCLES.
  - Afterward: FULL if buffer wr_ptr is busy, otherwise IDLE.
REQ-023 IDLE with a request while buffer wr_ptr is busy moves the block to FULL.
  - FULL returns to IDLE on the cycle after buffer wr_ptr is cleared.
REQ-024 Buffers are allocated strictly in ring order; the block never skips a busy buffer.
REQ-025 RF, PPS and ext requests arriving in HOLD or FULL are dropped and increment lost_count_o once per request.
REQ-026 A soft request arriving in HOLD or FULL sets a pending flag and issues at the first IDLE cycle with a free buffer.
  - The flag holds at most one request; a second soft request while pending counts as lost.
REQ-027 Simultaneous requests in one sampling cycle produce one trigger, with all requesting bits set in trig_type_o.
REQ-028 Clearing a buffer that is not busy is ignored.
REQ-029 Clear and allocation of the same buffer in one cycle: allocation uses the pre-clear busy state, and the clear takes effect at end of cycle.
REQ-030 disable_i asserted in ISSUE/HOLD/FULL does not abort the sequence; it only blocks new issues from IDLE.

Reset
REQ-031 With rst_n_i low at an edge:
  - State goes to IDLE; wr_ptr=0; buf_busy_o=0; all counters=0.
  - trig_o=0, trig_buf_o=0, trig_type_o=0; pending flag and edge detector are cleared.
  - This applies including mid-ISSUE and mid-HOLD.
REQ-032 A request coincident with the first cycle after reset is accepted normally.

Configuration
REQ-033 TRIG_DEADTIME_COUNT_EN defined: deadtime_count_o counts FULL cycles as in REQ-017.
REQ-034 TRIG_DEADTIME_COUNT_EN undefined: deadtime_count_o is tied to 0 and no counter logic is built.

Structure
REQ-035 Package anita3_trig_pkg holds:
  - the state enumeration;
  - source bit indices (SRC_RF=0, SRC_PPS=1, SRC_EXT=2, SRC_SOFT=3);
  - counter width constant CNT_W=16.
REQ-036 Sub-module anita3_buf_ring holds wr_ptr, the busy flags, and the clear/allocate rules of REQ-024, REQ-028 and REQ-029.

Verification
REQ-037 Reset, then a pps_trig_i pulse at cycle 10 -> trig_o at cycle 11, trig_buf_o=0, trig_type_o=0010, event_count_o=1.
REQ-038 Five RF edges 40 cycles apart with no clears -> four triggers on buffers 0,1,2,3, then FULL; the fifth edge gives lost_count_o=1 and deadtime_count_o increments each FULL cycle.
REQ-039 From FULL, clear_i with clear_buf_i=0 -> IDLE next cycle; the next RF edge issues on buffer 0.
REQ-040 soft_trig_i 5 cycles after a trigger -> pending; trig_o fires exactly 32 cycles after the prior trig_o, with trig_type_o=1000.
REQ-041 rf_trig_i edge and ext_trig_i in the same cycle, mask=0000 -> a single trig_o with trig_type_o=0101.
REQ-042 rst_n_i low during HOLD with buffers 0-1 busy -> buf_busy_o=0 and wr_ptr=0; the next request issues on buffer 0.
